flipdot_frame_tx: RTL

- Parametrised multi-panel flipdot frame transmitter. It sits between the ball_detector dot output and the EX_IO UART pin.
- Collects a binary dot image through a pixel write port into a write buffer.
- On frame end, snapshots the write buffer into a transmit buffer.
- Serialises one flipdot packet per panel over an 8N1 UART, with drop reporting and a frame counter.

---
 rtl/flipdot_frame_tx.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/flipdot_frame_tx.sv
// Multi-panel flipdot frame transmitter: double-buffered dot image, one 8N1
// packet per panel (80, CMD, addr, columns..., 8F) with drop reporting.
module flipdot_frame_tx #(
  parameter int          COLS          = 28,
  parameter int          ROWS          = 7,
  parameter int          PANELS        = 1,
  parameter logic [7:0]  BASE_ADDR     = 8'h00,
  parameter logic [7:0]  CMD           = 8'h83,
  parameter int          CLKS_PER_BIT  = 1311,
  parameter bit          CLEAR_ON_SWAP = 1'b1,
  localparam int         NCOL          = COLS * PANELS,
  localparam int         CW            = (NCOL > 1) ? $clog2(NCOL) : 1
) (
  input  logic          iCLK,
  input  logic          iRST_N,
  input  logic          iWR,
  input  logic [CW-1:0] iCOL,
  input  logic [2:0]    iROW,
  input  logic          iDOT,
  input  logic          iFRAME_END,
  input  logic          iFREEZE,
  output logic          oTXD,
  output logic          oBUSY,
  output logic          oFRAME_DROP,
  output logic [15:0]   oFRAMES_SENT
);
  localparam int IW = $clog2(COLS + 4);
  localparam int PW = (PANELS > 1) ? $clog2(PANELS) : 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  // Byte selection (LOAD) and byte/panel advance (NEXT) happen combinationally
  // inside the START and STOP bit periods, so bytes follow back to back.
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  state_t                   state_q, state_n;
  logic [BW-1:0]            baud_q, baud_n;
  logic [2:0]               bit_q, bit_n;
  logic [IW-1:0]            idx_q, idx_n;
  logic [PW-1:0]            pan_q, pan_n;
  logic                     txd_q, txd_n;
  logic                     drop_q, drop_n;
  logic [15:0]              frames_q, frames_n;
  logic [NCOL-1:0][ROWS-1:0] wbuf, tbuf;

  logic       wr_ok, fe, snap, baud_end, last_byte, last_pan;
  logic [CW-1:0] gcol;
  logic [7:0] cur_byte;

  assign wr_ok     = iWR && (int'(iCOL) < NCOL) && (int'(iROW) < ROWS);
  assign fe        = iFRAME_END && !iFREEZE;
  assign snap      = fe && (state_q == S_IDLE);
  assign baud_end  = (baud_q == BW'(CLKS_PER_BIT - 1));
  assign last_byte = (idx_q == IW'(COLS + 3));
  assign last_pan  = (pan_q == PW'(PANELS - 1));

  always_comb begin
    gcol     = CW'(int'(pan_q) * COLS + int'(idx_q) - 3);
    cur_byte = 8'h00;
    if (idx_q == IW'(0))      cur_byte = 8'h80;
    else if (idx_q == IW'(1)) cur_byte = CMD;
    else if (idx_q == IW'(2)) cur_byte = BASE_ADDR + 8'(pan_q);
    else if (last_byte)       cur_byte = 8'h8F;
    else                      cur_byte = 8'(tbuf[gcol]);
  end

  always_comb begin
    state_n  = state_q;
    baud_n   = baud_q;
    bit_n    = bit_q;
    idx_n    = idx_q;
    pan_n    = pan_q;
    txd_n    = txd_q;
    frames_n = frames_q;
    drop_n   = fe && (state_q != S_IDLE);
    case (state_q)
      S_IDLE: if (snap) begin
        state_n = S_START;
        baud_n  = '0;
        idx_n   = '0;
        pan_n   = '0;
        txd_n   = 1'b0;
      end
      S_START: if (baud_end) begin
        baud_n  = '0;
        bit_n   = 3'd0;
        state_n = S_DATA;
        txd_n   = cur_byte[0];
      end else baud_n = baud_q + 1'b1;
      S_DATA: if (baud_end) begin
        baud_n = '0;
        if (bit_q == 3'd7) begin
          state_n = S_STOP;
          txd_n   = 1'b1;
        end else begin
          bit_n = bit_q + 3'd1;
          txd_n = cur_byte[bit_n];
        end
      end else baud_n = baud_q + 1'b1;
      S_STOP: if (baud_end) begin
        baud_n = '0;
        if (last_byte && last_pan) begin
          state_n  = S_IDLE;
          idx_n    = '0;
          frames_n = frames_q + 16'd1;
        end else begin
          state_n = S_START;
          txd_n   = 1'b0;
          if (last_byte) begin
            idx_n = '0;
            pan_n = pan_q + 1'b1;
          end else idx_n = idx_q + 1'b1;
        end
      end else baud_n = baud_q + 1'b1;
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= '0;
      idx_q    <= '0;
      pan_q    <= '0;
      txd_q    <= 1'b1;
      drop_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_n;
      baud_q   <= baud_n;
      bit_q    <= bit_n;
      idx_q    <= idx_n;
      pan_q    <= pan_n;
      txd_q    <= txd_n;
      drop_q   <= drop_n;
      frames_q <= frames_n;
    end
  end

  // A write in the snapshot cycle lands on the freshly cleared buffer.
  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      wbuf <= '0;
      tbuf <= '0;
    end else begin
      if (snap) begin
        tbuf <= wbuf;
        if (CLEAR_ON_SWAP) wbuf <= '0;
      end
      if (wr_ok) wbuf[iCOL][iROW] <= iDOT;
    end
  end

  assign oTXD         = txd_q;
  assign oBUSY        = (state_q != S_IDLE);
  assign oFRAME_DROP  = drop_q;
  assign oFRAMES_SENT = frames_q;
endmodule
